// File: rtl/switch_pkg.sv
// switch_pkg: shared types and constants for the param_switch packet switch.
// Holds the input FSM state type, packet header byte offsets and the
// default data width used by the top and the per-port FIFO.
package switch_pkg;

   localparam int DATA_W_DEF = 8;

   // Header layout: DA, SA, LEN, then LEN payload bytes, then one FCS byte.
   localparam int DA_OFS         = 0;
   localparam int SA_OFS         = 1;
   localparam int LEN_OFS        = 2;
   localparam int FRAME_OVERHEAD = 4;

   // ROUTE is a reserved encoding: the DA lookup is resolved combinationally
   // in IDLE so a packet can start on the cycle right after the previous ends.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ROUTE   = 2'd1,
      STORE   = 2'd2,
      DISCARD = 2'd3
   } state_t;

endpackage

// File: rtl/switch_port_fifo.sv
// switch_port_fifo: per-port store-and-forward buffer.
// Writes land speculatively at wr_ptr; commit publishes them to the reader,
// rollback rewinds wr_ptr to the last commit point. Only committed bytes are
// visible through ready/rd_data. Pointers carry one extra wrap bit.
module switch_port_fifo
   import switch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit,
   input  logic              rollback,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              ready,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     commit_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   // Reader handshake: a pop happens on an edge where rd_en and ready are both
   // high; rd_data then shows the popped byte until the next accepted pop.
   // rd_en while not ready is ignored.
   assign ready = (commit_ptr != rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Pointer bookkeeping and the registered output byte.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         rd_data    <= '0;
      end else begin
         if (rollback) begin
            wr_ptr <= commit_ptr;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (commit) begin
            commit_ptr <= wr_ptr;
         end
         if (rd_en && ready) begin
            rd_ptr  <= rd_ptr + PW'(1);
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Byte storage; contents need no reset because pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/param_switch.sv
// param_switch: byte-serial input routed to NUM_PORTS store-and-forward ports
// by destination address, with a memory-style config interface for the port
// addresses and a saturating drop counter.
// Optional build macro PARAM_SWITCH_FCS_CHECK_EN: when defined, a packet only
// commits if its FCS byte equals the XOR of all preceding bytes.
module param_switch
   import switch_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 32,
   parameter int MAX_LEN    = 16,
   parameter int CFG_AW     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        data_status,
   input  logic [DATA_W-1:0]           data,
   output logic [NUM_PORTS*DATA_W-1:0] port_data,
   output logic [NUM_PORTS-1:0]        ready,
   input  logic [NUM_PORTS-1:0]        read,
   input  logic                        mem_en,
   input  logic                        mem_rd_wr,
   input  logic [CFG_AW-1:0]           mem_add,
   input  logic [DATA_W-1:0]           mem_wdata,
   output logic [DATA_W-1:0]           mem_rdata
);

   localparam logic [CFG_AW-1:0] DROP_CNT_ADDR = CFG_AW'(NUM_PORTS);
   localparam int SEL_W = $clog2(NUM_PORTS);
   localparam int CNT_W = $clog2(MAX_LEN + FRAME_OVERHEAD + 1);
   localparam int LW    = (DATA_W + 1 > CNT_W) ? DATA_W + 1 : CNT_W;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0]  drop_q;
   logic [DATA_W-1:0]  port_addr [NUM_PORTS];
   logic [DATA_W-1:0]  cfg_rd_val;

   logic               match_any;
   logic [SEL_W-1:0]   match_idx;
   logic               len_ok;
   logic               fcs_ok;
   logic               drop_inc;
   logic               wr_any, commit_any, rollback_any;
   logic [NUM_PORTS-1:0] wr_v, commit_v, rollback_v, full_v;

`ifdef PARAM_SWITCH_FCS_CHECK_EN
   logic [DATA_W-1:0]  acc_q, acc_d;
   // Running XOR over every stored byte; zero at end means FCS matched.
   assign fcs_ok = (acc_q == '0);
`else
   assign fcs_ok = 1'b1;
`endif

   // Count includes DA..FCS; LEN of zero is never a valid packet.
   assign len_ok = (LW'(cnt_q) == LW'(len_q) + LW'(FRAME_OVERHEAD)) && (len_q != '0);

   // DA lookup: scan high to low so the lowest matching index wins.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_addr[i] == data) begin
            match_any = 1'b1;
            match_idx = SEL_W'(i);
         end
      end
   end

   // Input FSM next state, write/commit/rollback strobes and drop events.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      drop_inc     = 1'b0;
      wr_any       = 1'b0;
      commit_any   = 1'b0;
      rollback_any = 1'b0;
`ifdef PARAM_SWITCH_FCS_CHECK_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (data_status) begin
               if (!match_any || full_v[match_idx]) begin
                  drop_inc = 1'b1;
                  state_d  = DISCARD;
               end else begin
                  wr_any  = 1'b1;
                  sel_d   = match_idx;
                  cnt_d   = CNT_W'(1);
                  len_d   = '0;
`ifdef PARAM_SWITCH_FCS_CHECK_EN
                  acc_d   = data;
`endif
                  state_d = STORE;
               end
            end
         end
         STORE: begin
            if (data_status) begin
               if (cnt_q == CNT_W'(MAX_LEN + FRAME_OVERHEAD) || full_v[sel_q]) begin
                  rollback_any = 1'b1;
                  drop_inc     = 1'b1;
                  state_d      = DISCARD;
               end else begin
                  wr_any = 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(LEN_OFS)) begin
                     len_d = data;
                  end
`ifdef PARAM_SWITCH_FCS_CHECK_EN
                  acc_d = acc_q ^ data;
`endif
               end
            end else begin
               if (len_ok && fcs_ok) begin
                  commit_any = 1'b1;
               end else begin
                  rollback_any = 1'b1;
                  drop_inc     = 1'b1;
               end
               state_d = IDLE;
            end
         end
         DISCARD: begin
            if (!data_status) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM registers; a reset landing mid-packet parks the input in DISCARD.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= data_status ? DISCARD : IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
`ifdef PARAM_SWITCH_FCS_CHECK_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
`ifdef PARAM_SWITCH_FCS_CHECK_EN
         acc_q   <= acc_d;
`endif
      end
   end

   // Config read mux: port addresses, drop counter, zero elsewhere.
   always_comb begin
      cfg_rd_val = '0;
      if (mem_add == DROP_CNT_ADDR) begin
         cfg_rd_val = drop_q;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (mem_add == CFG_AW'(i)) begin
            cfg_rd_val = port_addr[i];
         end
      end
   end

   // Config registers, saturating drop counter and registered read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_q    <= '0;
         mem_rdata <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            port_addr[i] <= DATA_W'(i);
         end
      end else begin
         if (mem_en && mem_rd_wr && mem_add == DROP_CNT_ADDR) begin
            drop_q <= '0;
         end else if (drop_inc && drop_q != '1) begin
            drop_q <= drop_q + DATA_W'(1);
         end
         if (mem_en && mem_rd_wr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (mem_add == CFG_AW'(i)) begin
                  port_addr[i] <= mem_wdata;
               end
            end
         end
         if (mem_en && !mem_rd_wr) begin
            mem_rdata <= cfg_rd_val;
         end
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign wr_v[g]       = wr_any && (sel_d == SEL_W'(g));
      assign commit_v[g]   = commit_any && (sel_q == SEL_W'(g));
      assign rollback_v[g] = rollback_any && (sel_q == SEL_W'(g));

      switch_port_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_v[g]),
         .wr_data  (data),
         .commit   (commit_v[g]),
         .rollback (rollback_v[g]),
         .rd_en    (read[g]),
         .rd_data  (port_data[g*DATA_W +: DATA_W]),
         .ready    (ready[g]),
         .full     (full_v[g])
      );
   end

endmodule

// File: tb/tb_param_switch.sv
// tb_param_switch: self-checking bench for param_switch. A packet-level model
// decides each packet's fate from the packet rules and keeps per-port
// queues of expected bytes, the address table and the drop count.
module tb_param_switch;

   localparam int NUM_PORTS  = 4;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 32;
   localparam int MAX_LEN    = 16;
   localparam int CFG_AW     = 4;

   typedef logic [7:0] byte_q_t[$];

   logic                        clk = 1'b0;
   logic                        reset = 1'b0;
   logic                        data_status = 1'b0;
   logic [DATA_W-1:0]           data = '0;
   logic [NUM_PORTS*DATA_W-1:0] port_data;
   logic [NUM_PORTS-1:0]        ready;
   logic [NUM_PORTS-1:0]        read = '0;
   logic                        mem_en = 1'b0;
   logic                        mem_rd_wr = 1'b0;
   logic [CFG_AW-1:0]           mem_add = '0;
   logic [DATA_W-1:0]           mem_wdata = '0;
   logic [DATA_W-1:0]           mem_rdata;

   param_switch #(
      .NUM_PORTS  (NUM_PORTS),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_LEN    (MAX_LEN),
      .CFG_AW     (CFG_AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_status (data_status),
      .data        (data),
      .port_data   (port_data),
      .ready       (ready),
      .read        (read),
      .mem_en      (mem_en),
      .mem_rd_wr   (mem_rd_wr),
      .mem_add     (mem_add),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] exp_q[NUM_PORTS][$];
   logic [7:0] addr_m[NUM_PORTS];
   logic [7:0] last_m[NUM_PORTS];
   int         drop_m;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM_PORTS; i++) begin
         exp_q[i].delete();
         addr_m[i] = 8'(i);
         last_m[i] = 8'h00;
      end
      drop_m = 0;
   endfunction

   function automatic logic [NUM_PORTS-1:0] model_ready();
      logic [NUM_PORTS-1:0] r;
      for (int i = 0; i < NUM_PORTS; i++) r[i] = (exp_q[i].size() != 0);
      return r;
   endfunction

   function automatic void model_drop();
      if (drop_m < 255) drop_m++;
   endfunction

   // Decide a whole packet's fate from the packet rules.
   function automatic void model_pkt(input byte_q_t b);
      int n = b.size();
      int port = -1;
      bit ok;
      logic [7:0] x;
      for (int i = NUM_PORTS - 1; i >= 0; i--) if (addr_m[i] == b[0]) port = i;
      if (port < 0) begin
         model_drop();
         return;
      end
      ok = 1'b1;
      if (n > MAX_LEN + 4) ok = 1'b0;
      if (n > FIFO_DEPTH - exp_q[port].size()) ok = 1'b0;
      if (n < 3 || n != int'(b[2]) + 4 || b[2] == 8'd0) ok = 1'b0;
`ifdef PARAM_SWITCH_FCS_CHECK_EN
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= b[i];
      if (x != b[n-1]) ok = 1'b0;
`else
      x = 8'h00;
`endif
      if (ok) begin
         foreach (b[i]) exp_q[port].push_back(b[i]);
      end else begin
         model_drop();
      end
   endfunction

   function automatic byte_q_t make_pkt(input logic [7:0] da, input logic [7:0] len_field,
                                        input int pay_len, input bit bad_fcs);
      byte_q_t q;
      logic [7:0] x;
      q.push_back(da);
      q.push_back(8'($urandom));
      q.push_back(len_field);
      for (int i = 0; i < pay_len; i++) q.push_back(8'($urandom));
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      if (bad_fcs) x ^= 8'h5A;
      q.push_back(x);
      return q;
   endfunction

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      model_reset();
   endtask

   task automatic send_pkt(input byte_q_t b, input string tag);
      model_pkt(b);
      foreach (b[i]) begin
         data_status = 1'b1;
         data = b[i];
         tick();
      end
      data_status = 1'b0;
      data = '0;
      tick();
      check({tag, "_ready"}, 64'(ready), 64'(model_ready()));
   endtask

   task automatic pop(input int p);
      read[p] = 1'b1;
      tick();
      read = '0;
      if (exp_q[p].size() != 0) last_m[p] = exp_q[p].pop_front();
      check($sformatf("pop%0d", p), 64'(port_data[p*DATA_W +: DATA_W]), 64'(last_m[p]));
      check("pop_ready", 64'(ready), 64'(model_ready()));
   endtask

   task automatic drain(input int p);
      while (exp_q[p].size() != 0) pop(p);
   endtask

   task automatic cfg_write(input int a, input logic [7:0] v);
      mem_en = 1'b1;
      mem_rd_wr = 1'b1;
      mem_add = CFG_AW'(a);
      mem_wdata = v;
      tick();
      mem_en = 1'b0;
      mem_rd_wr = 1'b0;
      if (a < NUM_PORTS) addr_m[a] = v;
      else if (a == NUM_PORTS) drop_m = 0;
   endtask

   task automatic cfg_read(input int a);
      logic [7:0] e;
      mem_en = 1'b1;
      mem_rd_wr = 1'b0;
      mem_add = CFG_AW'(a);
      tick();
      mem_en = 1'b0;
      if (a < NUM_PORTS) e = addr_m[a];
      else if (a == NUM_PORTS) e = 8'(drop_m);
      else e = 8'h00;
      check($sformatf("cfg_rd%0d", a), 64'(mem_rdata), 64'(e));
   endtask

   // Watchdog: the run is a fixed sequence, so this only fires on a stall.
   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t pkt;
      int kind, p, pay, lf, r;
      logic [7:0] da;

      model_reset();
      do_reset();
      check("rst_port_data", 64'(port_data), 64'(0));
      check("rst_ready", 64'(ready), 64'(0));
      check("rst_rdata", 64'(mem_rdata), 64'(0));
      for (int i = 0; i < 6; i++) cfg_read(i);

      // Routed packet to port 2
      cfg_write(2, 8'h22);
      cfg_read(2);
      pkt = '{8'h22, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      pkt.push_back(8'h22 ^ 8'h01 ^ 8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC);
      send_pkt(pkt, "route");
      check("route_ready_bits", 64'(ready), 64'(4'b0100));
      drain(2);
      pop(2);  // pop while not ready: slice holds

      // Unknown DA
      send_pkt(make_pkt(8'h55, 8'd2, 2, 1'b0), "unknown");
      cfg_read(NUM_PORTS);

      // Length mismatch then a good packet to port 0
      cfg_write(NUM_PORTS, 8'h00);
      send_pkt(make_pkt(8'h00, 8'd5, 3, 1'b0), "len_bad");
      cfg_read(NUM_PORTS);
      send_pkt(make_pkt(8'h00, 8'd4, 4, 1'b0), "len_good");
      drain(0);

      // Overflow on port 1, then an exact fit, then a full-port DA
      send_pkt(make_pkt(8'h01, 8'd12, 12, 1'b0), "ovf_fill");
      send_pkt(make_pkt(8'h01, 8'd16, 16, 1'b0), "ovf_drop");
      cfg_read(NUM_PORTS);
      send_pkt(make_pkt(8'h01, 8'd12, 12, 1'b0), "ovf_exact");
      send_pkt(make_pkt(8'h01, 8'd1, 1, 1'b0), "ovf_full");
      cfg_read(NUM_PORTS);
      drain(1);

      // Too long (LEN consistent but above MAX_LEN)
      send_pkt(make_pkt(8'h03, 8'(MAX_LEN + 1), MAX_LEN + 1, 1'b0), "too_long");
      send_pkt(make_pkt(8'h03, 8'(MAX_LEN), MAX_LEN, 1'b0), "max_len");
      drain(3);

      // Corrupt FCS: dropped only when the check is built in
      send_pkt(make_pkt(8'h03, 8'd3, 3, 1'b1), "bad_fcs");
      cfg_read(NUM_PORTS);
      drain(3);

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         kind = $urandom_range(0, 9);
         r = $urandom_range(0, 5);
         if (r < NUM_PORTS) da = addr_m[r];
         else if (r == 4) da = 8'h55;
         else da = 8'($urandom);
         pay = $urandom_range(1, MAX_LEN);
         lf = pay;
         if (kind == 0) pay = ($urandom_range(0, 1) != 0) ? pay + 1 : pay - 1;
         if (kind == 2) begin lf = 0; pay = 0; end
         if (kind == 3) begin lf = MAX_LEN + 1; pay = MAX_LEN + 1; end
         send_pkt(make_pkt(da, 8'(lf), pay, kind == 1), "rnd");
         for (int k = 0; k < int'($urandom_range(0, 6)); k++) pop($urandom_range(0, NUM_PORTS - 1));
         if ($urandom_range(0, 7) == 0) begin
            p = $urandom_range(0, NUM_PORTS - 1);
            cfg_write(p, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
         end
         if ($urandom_range(0, 3) == 0) cfg_read($urandom_range(0, 7));
      end
      for (int i = 0; i < NUM_PORTS; i++) drain(i);
      cfg_read(NUM_PORTS);

      // Reset mid-packet, then a good packet
      cfg_write(0, 8'h40);
      send_pkt(make_pkt(8'h40, 8'd2, 2, 1'b0), "pre_rst");
      pkt = make_pkt(8'h00, 8'd6, 6, 1'b0);
      for (int i = 0; i < 10; i++) begin
         data_status = 1'b1;
         data = pkt[i];
         if (i == 5) reset = 1'b0;
         if (i == 7) begin
            reset = 1'b1;
            model_reset();
         end
         tick();
      end
      data_status = 1'b0;
      data = '0;
      tick();
      check("mid_rst_port_data", 64'(port_data), 64'(0));
      check("mid_rst_ready", 64'(ready), 64'(0));
      check("mid_rst_rdata", 64'(mem_rdata), 64'(0));
      for (int i = 0; i <= NUM_PORTS; i++) cfg_read(i);
      send_pkt(make_pkt(8'h00, 8'd5, 5, 1'b0), "post_rst");
      drain(0);

      // Drop counter saturation and clear
      for (int i = 0; i < 260; i++) send_pkt(make_pkt(8'h55, 8'd1, 1, 1'b0), "sat");
      cfg_read(NUM_PORTS);
      check("sat_model", 64'(mem_rdata), 64'(255));
      cfg_write(NUM_PORTS, 8'hFF);
      cfg_read(NUM_PORTS);
      cfg_read(NUM_PORTS + 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
